// File: rtl/servo_pulse_decoder.sv
// Servo PWM pulse-width decoder: measures each high pulse and maps it to an 8-bit position.
// Define SERVO_DECODER_GLITCH_FILTER_EN to add a 4-cycle persistence filter after the synchronizer.
`timescale 1ns/1ps
module servo_pulse_decoder #(
  parameter int MIN_TICKS     = 50000,
  parameter int STEP_TICKS    = 196,
  parameter int SHORT_TICKS   = 25000,
  parameter int LONG_TICKS    = 150000,
  parameter int TIMEOUT_TICKS = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       servo_in,
  output logic [7:0] position,
  output logic       valid,
  output logic       short_err,
  output logic       long_err,
  output logic       signal_lost
);
  localparam int WW = $clog2(LONG_TICKS + 2);
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [WW-1:0] MIN_W     = WW'(MIN_TICKS);
  localparam logic [WW-1:0] SHORT_W   = WW'(SHORT_TICKS);
  localparam logic [WW-1:0] LONG_W    = WW'(LONG_TICKS);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_TICKS);

  localparam logic [1:0] WAIT_LOW = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] MEASURE  = 2'd2;
  localparam logic [1:0] OVERLONG = 2'd3;

  logic [1:0] sync_q;
  logic       s_raw, s, s_d, rise;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], servo_in};
  end
  assign s_raw = sync_q[1];

`ifdef SERVO_DECODER_GLITCH_FILTER_EN
  // s follows s_raw only after the new level has persisted for 4 cycles
  localparam logic [2:0] PRIME = 3'd6;
  logic       s_f;
  logic [1:0] flt_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_f     <= 1'b0;
      flt_cnt <= '0;
    end else if (s_raw == s_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == 2'd3) begin
      s_f     <= s_raw;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
  assign s = s_f;
`else
  localparam logic [2:0] PRIME = 3'd2;
  assign s = s_raw;
`endif

  // The synchronizer resets low, so a low s is only trusted once real input samples reach it;
  // otherwise a pulse already high at reset release would look like a fresh rising edge.
  logic [2:0] prime_cnt;
  logic       primed;
  always_ff @(posedge clk) begin
    if (rst)                  prime_cnt <= '0;
    else if (prime_cnt != PRIME) prime_cnt <= prime_cnt + 1'b1;
  end
  assign primed = (prime_cnt == PRIME);

  assign rise = s & ~s_d;

  logic [1:0]    state;
  logic [WW-1:0] w, w_inc;
  logic [SW-1:0] step_cnt;
  logic [7:0]    acc;
  logic [TW-1:0] to_cnt;

  assign w_inc = w + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_LOW;
      s_d         <= 1'b0;
      w           <= '0;
      step_cnt    <= '0;
      acc         <= '0;
      to_cnt      <= '0;
      position    <= 8'd128;
      valid       <= 1'b0;
      short_err   <= 1'b0;
      long_err    <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      s_d       <= s;
      valid     <= 1'b0;
      short_err <= 1'b0;
      long_err  <= 1'b0;

      if (rise)                  to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_MAX)      signal_lost <= 1'b1;

      case (state)
        WAIT_LOW: if (primed && !s) state <= ARMED;
        ARMED: begin
          if (rise) begin
            state    <= MEASURE;
            w        <= {{(WW-1){1'b0}}, 1'b1};
            step_cnt <= '0;
            acc      <= '0;
          end
        end
        MEASURE: begin
          if (s) begin
            w <= w_inc;
            if (w_inc > LONG_W) begin
              long_err <= 1'b1;
              state    <= OVERLONG;
            end else if (w_inc > MIN_W) begin
              // divider-free decode: acc counts whole STEP_TICKS periods beyond MIN_TICKS
              if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (acc != 8'hFF) acc <= acc + 1'b1;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end
          end else begin
            state <= ARMED;
            if (w < SHORT_W) begin
              short_err <= 1'b1;
            end else begin
              position    <= acc;
              valid       <= 1'b1;
              signal_lost <= 1'b0;
            end
          end
        end
        OVERLONG: if (!s) state <= ARMED;
        default:  state <= WAIT_LOW;
      endcase
    end
  end
endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder with scaled-down timing parameters.
`timescale 1ns/1ps
module tb_servo_pulse_decoder;
  localparam int MIN   = 1020;
  localparam int STEP  = 4;
  localparam int SHORT = 510;
  localparam int LONG  = 3060;
  localparam int TMO   = 8000;
`ifdef SERVO_DECODER_GLITCH_FILTER_EN
  localparam int FLT = 4;
`else
  localparam int FLT = 0;
`endif

  logic       clk = 1'b0, rst = 1'b1, servo_in = 1'b0;
  logic [7:0] position;
  logic       valid, short_err, long_err, signal_lost;

  servo_pulse_decoder #(
    .MIN_TICKS(MIN), .STEP_TICKS(STEP), .SHORT_TICKS(SHORT),
    .LONG_TICKS(LONG), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .servo_in(servo_in), .position(position),
    .valid(valid), .short_err(short_err), .long_err(long_err), .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rise_cyc = 0;
  int n_valid = 0, n_short = 0, n_long = 0, n_ovl = 0, long_at = 0;
  always @(negedge clk) begin
    if (valid) n_valid++;
    if (short_err) n_short++;
    if (long_err) begin n_long++; long_at = cyc - rise_cyc; end
    if (int'(valid) + int'(short_err) + int'(long_err) > 1) n_ovl++;
  end

  int checks = 0, failures = 0;
  int exp_pos = 128;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: 0 accepted, 1 too short, 2 too long
  function automatic int model_kind(input int w);
    if (w < SHORT) return 1;
    if (w > LONG)  return 2;
    return 0;
  endfunction

  function automatic int model_pos(input int w);
    int p;
    p = (w <= MIN) ? 0 : (w - MIN) / STEP;
    return (p > 255) ? 255 : p;
  endfunction

  task automatic pulse(input int w, input int gap);
    @(posedge clk); #1;
    servo_in = 1'b1;
    rise_cyc = cyc;
    repeat (w) @(posedge clk);
    #1 servo_in = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic run_pulse(input string nm, input int w, input int kind, input int pos);
    int bv, bs, bl, bo;
    bv = n_valid; bs = n_short; bl = n_long; bo = n_ovl;
    pulse(w, 20);
    chk({nm, ".valid"}, n_valid - bv, int'(kind == 0));
    chk({nm, ".short"}, n_short - bs, int'(kind == 1));
    chk({nm, ".long"},  n_long - bl,  int'(kind == 2));
    chk({nm, ".excl"},  n_ovl - bo, 0);
    if (kind == 0) exp_pos = pos;
    chk({nm, ".pos"}, int'(position), exp_pos);
    if (kind == 2) chk({nm, ".long_at"}, long_at, LONG + 3 + FLT);
  endtask

  typedef struct { int w; int kind; int pos; } vec_t;
  vec_t vecs[12];

  initial begin
    int w, bv, bs, bl;
    vecs[0]  = '{1530, 0, 127};
    vecs[1]  = '{1020, 0, 0};
    vecs[2]  = '{2040, 0, 255};
    vecs[3]  = '{2244, 0, 255};
    vecs[4]  = '{408,  1, 0};
    vecs[5]  = '{3264, 2, 0};
    vecs[6]  = '{510,  0, 0};
    vecs[7]  = '{509,  1, 0};
    vecs[8]  = '{3060, 0, 255};
    vecs[9]  = '{3061, 2, 0};
    vecs[10] = '{1023, 0, 0};
    vecs[11] = '{1024, 0, 1};

    repeat (4) @(posedge clk);
    #1;
    chk("rst.position", int'(position), 128);
    chk("rst.valid", int'(valid), 0);
    chk("rst.short", int'(short_err), 0);
    chk("rst.long", int'(long_err), 0);
    chk("rst.lost", int'(signal_lost), 1);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      run_pulse($sformatf("vec%0d", i), vecs[i].w, vecs[i].kind, vecs[i].pos);
      if (i == 0) chk("vec0.lost", int'(signal_lost), 0);
    end

    for (int i = 0; i < 10; i++) begin
      w = int'($urandom_range(300, 3400));
      run_pulse($sformatf("rnd%0d_w%0d", i, w), w, model_kind(w), model_pos(w));
    end

    // signal loss: no rising edge for TMO cycles after the last pulse
    run_pulse("to.pre", 1530, 0, 127);
    w = rise_cyc + TMO + 4 + FLT;
    while (cyc < w - 5) @(posedge clk);
    #1 chk("to.before", int'(signal_lost), 0);
    while (cyc < w + 5) @(posedge clk);
    #1 chk("to.after", int'(signal_lost), 1);
    chk("to.hold", int'(position), 127);
    run_pulse("to.short", 408, 1, 0);
    chk("to.short_lost", int'(signal_lost), 1);
    run_pulse("to.recover", 2040, 0, 255);
    chk("to.recover_lost", int'(signal_lost), 0);

    // reset mid-pulse, input still high at release: that pulse must never be measured
    @(posedge clk); #1 servo_in = 1'b1;
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rstmid.position", int'(position), 128);
    chk("rstmid.lost", int'(signal_lost), 1);
    bv = n_valid; bs = n_short; bl = n_long;
    repeat (2040) @(posedge clk);
    #1 servo_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rstmid.strobes", (n_valid - bv) + (n_short - bs) + (n_long - bl), 0);
    chk("rstmid.pos_held", int'(position), 128);
    exp_pos = 128;
    run_pulse("rstmid.second", 2040, 0, 255);

`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    bv = n_valid; bs = n_short; bl = n_long;
    @(posedge clk); #1 servo_in = 1'b1;
    repeat (700) @(posedge clk);
    #1 servo_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 servo_in = 1'b1;
    repeat (827) @(posedge clk);
    #1 servo_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch.valid", n_valid - bv, 1);
    chk("glitch.err", (n_short - bs) + (n_long - bl), 0);
    chk("glitch.pos", int'(position), 127);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/servo_pulse_decoder.md
SERVO_PULSE_DECODER -- requirements
Module: servo_pulse_decoder

Interface
REQ-001 SHALL have parameter MIN_TICKS, default 50000, meaning pulse width in clk cycles that decodes to position 0 (1.0 ms at 50 MHz).
REQ-002 SHALL have parameter STEP_TICKS, default 196, meaning clk cycles per position step.
REQ-003 SHALL have parameter SHORT_TICKS, default 25000, meaning the shortest accepted pulse (0.5 ms).
REQ-004 SHALL have parameter LONG_TICKS, default 150000, meaning the longest accepted pulse (3.0 ms).
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 1250000, meaning the no-rising-edge interval that declares signal loss (25 ms).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, 50 MHz.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port servo_in, input, 1 bit: asynchronous servo PWM pulse input, high during the pulse.
REQ-009 SHALL have port position, output, 8 bits: last accepted decoded position.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle strobe, high when position has just been updated.
REQ-011 SHALL have port short_err, output, 1 bit: one-cycle strobe, high when a pulse is rejected as too short.
REQ-012 SHALL have port long_err, output, 1 bit: one-cycle strobe, high when a pulse is rejected as too long.
REQ-013 SHALL have port signal_lost, output, 1 bit: level, high while no valid signal is present.

Function
REQ-014 SHALL pass servo_in through a 2-flop synchronizer; the synchronizer output is s, and all widths are counted on s.
REQ-015 SHALL implement the states WAIT_LOW, ARMED, MEASURE and OVERLONG.
REQ-016 WAIT_LOW SHALL go to ARMED on the first cycle in which s=0.
REQ-017 ARMED SHALL go to MEASURE on the rising edge of s; that cycle is counted as width W=1.
REQ-018 MEASURE SHALL increment W on every cycle in which s=1.
REQ-019 MEASURE SHALL decode the position without a divider: a step sub-counter wraps at STEP_TICKS and increments an 8-bit accumulator, starting once W exceeds MIN_TICKS and saturating at 255.
REQ-020 When W exceeds LONG_TICKS, MEASURE SHALL go to OVERLONG and strobe long_err for one cycle.
REQ-021 OVERLONG SHALL go to ARMED when s=0, with no further strobe.
REQ-022 On a falling edge in MEASURE with W < SHORT_TICKS, the block SHALL strobe short_err on the next cycle, leave position unchanged, and go to ARMED.
REQ-023 On a falling edge in MEASURE with SHORT_TICKS <= W <= LONG_TICKS, the block SHALL, on the next cycle, set position to min(255, floor(max(0, W-MIN_TICKS)/STEP_TICKS)), assert valid for one cycle, clear signal_lost, and go to ARMED.
REQ-024 The error and valid strobes SHALL be mutually exclusive, and at most one strobe SHALL occur per pulse.
REQ-025 A timeout counter SHALL clear on every rising edge of s and saturate at TIMEOUT_TICKS.
REQ-026 signal_lost SHALL be set when the timeout counter reaches TIMEOUT_TICKS, and SHALL be cleared only by an accepted pulse.
REQ-027 position SHALL hold its value while signal_lost is high.
REQ-028 All counters SHALL be sized to hold their maximum value without wrap-around.

Reset
REQ-029 The block SHALL enter WAIT_LOW on reset, so that a pulse already high when reset releases is never measured.
REQ-030 Reset values SHALL be: position=8'd128, valid=0, short_err=0, long_err=0, signal_lost=1, synchronizer flops=0, all counters=0.
REQ-031 Reset asserted mid-pulse SHALL abort the measurement with no strobe output.

Configuration
REQ-032 With SERVO_DECODER_GLITCH_FILTER_EN defined, s SHALL change only after the synchronizer output has held a new level for 4 consecutive cycles; pulses or gaps of 3 cycles or fewer SHALL be ignored, and latency SHALL increase by 4 cycles on both edges, leaving W unchanged.
REQ-033 Without SERVO_DECODER_GLITCH_FILTER_EN, s SHALL be the raw synchronizer output, and the filter logic SHALL be absent.

Verification
REQ-034 After reset, a pulse of W=75000 SHALL produce valid for one cycle, position=127 and signal_lost=0.
REQ-035 Pulses of W=50000, W=100000 and W=110000 SHALL produce position=0, position=255 and position=255 (saturated), each with valid.
REQ-036 A pulse of W=20000 SHALL produce short_err for one cycle, no valid, and position unchanged; a pulse of W=160000 SHALL produce long_err once at W=150001 and no valid.
REQ-037 With servo_in held high across reset release and then a 100000-cycle pulse, the block SHALL produce no strobe for the first pulse and position=255 from the second pulse.
REQ-038 With no rising edge for 1250000 cycles after the last pulse, signal_lost SHALL go to 1 and position SHALL be held; the next valid pulse SHALL clear signal_lost.
REQ-039 With SERVO_DECODER_GLITCH_FILTER_EN defined, a 3-cycle low glitch inside a 75000-cycle pulse SHALL give one valid with position=127.
